// File: rtl/rvh_l1d_snp_lst_ctrl.sv
// rvh_l1d_snp_lst_ctrl: snoop-side writer of the L1D line state table (LST).
//   Accepts one snoop at a time, looks up the target line's MESI state, fetches
//   dirty data when the line is MODIFIED, writes the downgraded state back into
//   the LST and returns a response to the coherence agent.
//   Ports:
//     snp_req_*        snoop request (valid/ready, set, way, hit, type, id)
//     lst_rd_*         combinational LST read port (index out, line state in)
//     lst_mesi_wr_*_s0 pipeline-side LST write, monitored for hazards and priority
//     lst_mesi_wr_*_snp snoop-side LST write port
//     snp_dat_rd_*     dirty-data read request / completion
//     snp_resp_*       snoop response (valid/ready, id, has_data, previous state)
//     busy_o           snoop in flight; upstream holds pipeline writes to the line
package rvh_l1d_snp_lst_pkg;
    localparam int L1D_BANK_SET_INDEX_WIDTH = 6;
    localparam int L1D_BANK_WAY_INDEX_WIDTH = 2;
    localparam int L1D_BANK_WAY_NUM = 1 << L1D_BANK_WAY_INDEX_WIDTH;
    typedef enum logic [1:0] {
        INVALID   = 2'd0,
        SHARED    = 2'd1,
        EXCLUSIVE = 2'd2,
        MODIFIED  = 2'd3
    } rrv64_mesi_type_e;
    typedef struct packed {
        logic [L1D_BANK_WAY_NUM-1:0][1:0] mesi_sta;
    } rrv64_l1d_lst_t;
endpackage

module rvh_l1d_snp_lst_ctrl
    import rvh_l1d_snp_lst_pkg::*;
#(
    parameter int SNP_ID_W = 4
) (
    input  logic                                clk,
    input  logic                                rstn,
    input  logic                                snp_req_valid_i,
    output logic                                snp_req_ready_o,
    input  logic [L1D_BANK_SET_INDEX_WIDTH-1:0] snp_req_set_idx_i,
    input  logic [L1D_BANK_WAY_INDEX_WIDTH-1:0] snp_req_way_idx_i,
    input  logic                                snp_req_hit_i,
    input  logic                                snp_req_type_i,
    input  logic [SNP_ID_W-1:0]                 snp_req_id_i,
    output logic [L1D_BANK_SET_INDEX_WIDTH-1:0] lst_rd_idx_o,
    input  rrv64_l1d_lst_t                      lst_rd_dat_i,
    input  logic                                lst_mesi_wr_en_s0_req_i,
    input  logic [L1D_BANK_SET_INDEX_WIDTH-1:0] lst_mesi_wr_set_idx_s0_req_i,
    input  logic [L1D_BANK_WAY_INDEX_WIDTH-1:0] lst_mesi_wr_way_idx_s0_req_i,
    output logic                                lst_mesi_wr_en_snp_o,
    output logic [L1D_BANK_SET_INDEX_WIDTH-1:0] lst_mesi_wr_set_idx_snp_o,
    output logic [L1D_BANK_WAY_INDEX_WIDTH-1:0] lst_mesi_wr_way_idx_snp_o,
    output rrv64_mesi_type_e                    lst_mesi_wr_dat_snp_o,
    output logic                                snp_dat_rd_valid_o,
    input  logic                                snp_dat_rd_ready_i,
    input  logic                                snp_dat_rd_done_i,
    output logic                                snp_resp_valid_o,
    input  logic                                snp_resp_ready_i,
    output logic [SNP_ID_W-1:0]                 snp_resp_id_o,
    output logic                                snp_resp_has_data_o,
    output rrv64_mesi_type_e                    snp_resp_prev_sta_o,
    output logic                                busy_o
);
    typedef enum logic [2:0] {IDLE, LOOKUP, DATA_REQ, DATA_WAIT, UPDATE, RESP} state_e;

    state_e                              state_q;
    logic [L1D_BANK_SET_INDEX_WIDTH-1:0] set_q;
    logic [L1D_BANK_WAY_INDEX_WIDTH-1:0] way_q;
    logic                                hit_q;
    logic                                type_q;
    logic [SNP_ID_W-1:0]                 id_q;
    rrv64_mesi_type_e                    prev_q, prev_d, nxt_q, nxt_d;
    logic                                same_line_s0;

    // A pipeline write to the captured line during LOOKUP would make the read stale.
    assign same_line_s0 = lst_mesi_wr_en_s0_req_i
                          && lst_mesi_wr_set_idx_s0_req_i == set_q
                          && lst_mesi_wr_way_idx_s0_req_i == way_q;

    always_comb begin
        prev_d = hit_q ? rrv64_mesi_type_e'(lst_rd_dat_i.mesi_sta[way_q]) : INVALID;
        nxt_d  = type_q ? INVALID
               : (prev_d == MODIFIED || prev_d == EXCLUSIVE) ? SHARED : prev_d;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            set_q   <= '0;
            way_q   <= '0;
            hit_q   <= 1'b0;
            type_q  <= 1'b0;
            id_q    <= '0;
            prev_q  <= INVALID;
            nxt_q   <= INVALID;
        end else begin
            case (state_q)
                IDLE: if (snp_req_valid_i) begin
                    set_q   <= snp_req_set_idx_i;
                    way_q   <= snp_req_way_idx_i;
                    hit_q   <= snp_req_hit_i;
                    type_q  <= snp_req_type_i;
                    id_q    <= snp_req_id_i;
                    state_q <= LOOKUP;
                end
                LOOKUP: if (!same_line_s0) begin
                    prev_q  <= prev_d;
                    nxt_q   <= nxt_d;
                    state_q <= prev_d == MODIFIED ? DATA_REQ : nxt_d != prev_d ? UPDATE : RESP;
                end
                DATA_REQ:  if (snp_dat_rd_ready_i) state_q <= DATA_WAIT;
                DATA_WAIT: if (snp_dat_rd_done_i) state_q <= UPDATE;
                // The LST write mux favours the pipeline, so retry until its port is free.
                UPDATE:    if (!lst_mesi_wr_en_s0_req_i) state_q <= RESP;
                RESP:      if (snp_resp_ready_i) state_q <= IDLE;
                default:   state_q <= IDLE;
            endcase
        end
    end

    assign snp_req_ready_o           = state_q == IDLE;
    assign busy_o                    = state_q != IDLE;
    assign lst_rd_idx_o              = set_q;
    assign lst_mesi_wr_en_snp_o      = state_q == UPDATE && !lst_mesi_wr_en_s0_req_i;
    assign lst_mesi_wr_set_idx_snp_o = set_q;
    assign lst_mesi_wr_way_idx_snp_o = way_q;
    assign lst_mesi_wr_dat_snp_o     = nxt_q;
    assign snp_dat_rd_valid_o        = state_q == DATA_REQ;
    assign snp_resp_valid_o          = state_q == RESP;
    assign snp_resp_id_o             = id_q;
    assign snp_resp_has_data_o       = prev_q == MODIFIED;
    assign snp_resp_prev_sta_o       = prev_q;

    // Once the state has been sampled, the pipeline must leave the snooped line alone.
    a_no_s0_on_snooped_line: assert property (@(posedge clk) disable iff (!rstn)
        !(busy_o && state_q != LOOKUP && same_line_s0));
endmodule

// File: tb/tb_rvh_l1d_snp_lst_ctrl.sv
// tb_rvh_l1d_snp_lst_ctrl: directed and random snoops against an LST array model.
module tb_rvh_l1d_snp_lst_ctrl;
    import rvh_l1d_snp_lst_pkg::*;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic req_valid = 1'b0, req_ready, req_hit = 1'b0, req_type = 1'b0;
    logic [5:0] req_set = '0, rd_idx, wr_set, s0_set = '0;
    logic [1:0] req_way = '0, wr_way, s0_way = '0, s0_dat = '0, wr_dat, prev_sta;
    logic [3:0] req_id = '0, resp_id;
    rrv64_l1d_lst_t rd_dat;
    logic s0_en = 1'b0, wr_en, dat_valid, dat_ready = 1'b0, dat_done = 1'b0;
    logic resp_valid, resp_ready = 1'b0, has_data, busy;
    logic [1:0] lst [64][4];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    rvh_l1d_snp_lst_ctrl #(.SNP_ID_W(4)) dut (
        .clk(clk), .rstn(rstn),
        .snp_req_valid_i(req_valid), .snp_req_ready_o(req_ready),
        .snp_req_set_idx_i(req_set), .snp_req_way_idx_i(req_way),
        .snp_req_hit_i(req_hit), .snp_req_type_i(req_type), .snp_req_id_i(req_id),
        .lst_rd_idx_o(rd_idx), .lst_rd_dat_i(rd_dat),
        .lst_mesi_wr_en_s0_req_i(s0_en), .lst_mesi_wr_set_idx_s0_req_i(s0_set),
        .lst_mesi_wr_way_idx_s0_req_i(s0_way),
        .lst_mesi_wr_en_snp_o(wr_en), .lst_mesi_wr_set_idx_snp_o(wr_set),
        .lst_mesi_wr_way_idx_snp_o(wr_way), .lst_mesi_wr_dat_snp_o(wr_dat),
        .snp_dat_rd_valid_o(dat_valid), .snp_dat_rd_ready_i(dat_ready),
        .snp_dat_rd_done_i(dat_done),
        .snp_resp_valid_o(resp_valid), .snp_resp_ready_i(resp_ready),
        .snp_resp_id_o(resp_id), .snp_resp_has_data_o(has_data),
        .snp_resp_prev_sta_o(prev_sta), .busy_o(busy)
    );

    // LST model: the pipeline write wins the port, otherwise the snoop write lands.
    always @(posedge clk)
        if (s0_en) lst[s0_set][s0_way] <= s0_dat;
        else if (wr_en) lst[wr_set][wr_way] <= wr_dat;

    always_comb
        for (int i = 0; i < 4; i++) rd_dat.mesi_sta[i] = lst[rd_idx][i];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic poke(input logic [5:0] s, input logic [1:0] w, input logic [1:0] v);
        @(posedge clk); #1;
        s0_en = 1'b1; s0_set = s; s0_way = w; s0_dat = v;
        @(posedge clk); #1;
        s0_en = 1'b0;
    endtask

    // lk >= 0: pipeline rewrites the line with lk during LOOKUP.
    // stall: cycles the pipeline holds its write port (other set) once UPDATE is reached.
    task automatic snoop(input logic [5:0] s, input logic [1:0] w, input logic h, input logic t,
                         input logic [3:0] id, input bit fast, input int stall, input int lk);
        logic [1:0] ep, en, lkv;
        int lkx, wc, wcyc, rcyc;
        bit dseen, fin;
        lkv = 2'(lk);
        lkx = lk >= 0 ? 1 : 0;
        wc = 0; wcyc = 0; rcyc = 0; dseen = 0; fin = 0;
        @(posedge clk); #1;
        req_valid = 1'b1; req_set = s; req_way = w; req_hit = h; req_type = t; req_id = id;
        ep = !h ? INVALID : lkx != 0 ? lkv : lst[s][w];
        en = t ? INVALID : (ep == MODIFIED || ep == EXCLUSIVE) ? SHARED : ep;
        #1 chk("ready_idle", {31'd0, req_ready}, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int c = 1; c <= 60 && !fin; c++) begin
            s0_en = 1'b0;
            if (c == 1 && lkx != 0) begin
                s0_en = 1'b1; s0_set = s; s0_way = w; s0_dat = lkv;
            end else if (c >= 2 + lkx && c < 2 + lkx + stall) begin
                s0_en = 1'b1; s0_set = s + 6'd1; s0_way = 2'd0; s0_dat = 2'($urandom);
            end
            dat_ready  = fast ? 1'b1 : 1'($urandom);
            dat_done   = fast ? 1'b1 : 1'($urandom);
            resp_ready = fast ? 1'b1 : 1'($urandom);
            #1;
            if (c == 1) chk("busy_not_ready", {30'd0, busy, req_ready}, 2);
            if (dat_valid) dseen = 1;
            if (wr_en) begin
                wc++; wcyc = c;
                chk("wr_line_dat", {20'd0, wr_set, wr_way, wr_dat}, {20'd0, s, w, en});
            end
            if (resp_valid) begin
                chk("resp_fields", {25'd0, resp_id, has_data, prev_sta},
                    {25'd0, id, ep == MODIFIED, ep});
                if (resp_ready) begin rcyc = c; fin = 1; end
            end
            if (!fin) begin @(posedge clk); #1; end
        end
        s0_en = 1'b0;
        chk("resp_seen", {31'd0, fin}, 1);
        chk("wr_count", wc, en != ep ? 1 : 0);
        chk("data_req", {31'd0, dseen}, {31'd0, ep == MODIFIED});
        if (fast && ep != MODIFIED) begin
            if (en != ep) chk("wr_latency", wcyc, 2 + lkx + stall);
            chk("resp_latency", rcyc, en != ep ? 3 + lkx + stall : 2 + lkx);
        end
    endtask

    initial begin
        #1;
        chk("rst_ready_busy", {30'd0, req_ready, busy}, 2);
        chk("rst_strobes", {29'd0, wr_en, dat_valid, resp_valid}, 0);
        chk("rst_data", {14'd0, rd_idx, wr_set, wr_way, wr_dat, resp_id, has_data, prev_sta},
            0);
        @(posedge clk); #1 rstn = 1'b1;
        for (int s = 0; s < 16; s++)
            for (int w = 0; w < 4; w++) poke(6'(s), 2'(w), 2'($urandom));
        poke(6'd20, 2'd2, EXCLUSIVE);
        snoop(6'd20, 2'd2, 1'b1, 1'b0, 4'd1, 1, 0, -1);
        poke(6'd21, 2'd1, MODIFIED);
        snoop(6'd21, 2'd1, 1'b1, 1'b1, 4'd2, 1, 0, -1);
        snoop(6'd22, 2'd0, 1'b0, 1'b1, 4'd3, 1, 0, -1);
        poke(6'd23, 2'd3, EXCLUSIVE);
        snoop(6'd23, 2'd3, 1'b1, 1'b0, 4'd4, 1, 3, -1);
        poke(6'd24, 2'd0, SHARED);
        snoop(6'd24, 2'd0, 1'b1, 1'b1, 4'd5, 1, 0, EXCLUSIVE);
        poke(6'd25, 2'd1, SHARED);
        snoop(6'd25, 2'd1, 1'b1, 1'b0, 4'd6, 1, 0, -1);
        chk("lst_after_inv", {30'd0, lst[21][1]}, INVALID);
        // Reset while waiting for dirty data abandons the snoop.
        poke(6'd30, 2'd1, MODIFIED);
        @(posedge clk); #1;
        req_valid = 1'b1; req_set = 6'd30; req_way = 2'd1; req_hit = 1'b1; req_type = 1'b1;
        req_id = 4'd9; dat_ready = 1'b1; dat_done = 1'b0; resp_ready = 1'b0;
        @(posedge clk); #1 req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 chk("in_data_wait", {30'd0, busy, dat_valid}, 2);
        rstn = 1'b0;
        dat_done = 1'b1; resp_ready = 1'b1;
        #1 chk("async_rst", {28'd0, req_ready, busy, wr_en, resp_valid}, 8);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("rst_quiet", {29'd0, wr_en, resp_valid, req_ready}, 1);
        end
        rstn = 1'b1; dat_done = 1'b0; resp_ready = 1'b0;
        chk("lst_untouched", {30'd0, lst[30][1]}, MODIFIED);
        snoop(6'd30, 2'd1, 1'b1, 1'b1, 4'd10, 1, 0, -1);
        for (int n = 0; n < 40; n++) begin
            logic [5:0] s;
            logic [1:0] w;
            s = 6'($urandom_range(0, 15));
            w = 2'($urandom);
            poke(s, w, 2'($urandom));
            snoop(s, w, 1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom),
                  1'($urandom), 0, -1);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
